// File: rtl/inst_mem_loader.sv
// Boot loader: packs a UART byte stream (16-bit word-count header, little-endian words,
// XOR checksum) into instruction-memory writes and releases the core reset on a good load.
module inst_mem_loader #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iByteValid,
    input  logic [7:0]  iByte,
    input  logic        iStart,
    output logic        oWrEn,
    output logic [31:0] oWrAddr,
    output logic [31:0] oWrData,
    output logic        oCpuRst,
    output logic        oDone,
    output logic        oErr
);

    localparam int          IDX_W   = $clog2(DEPTH + 1);
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    typedef enum logic [2:0] {
        CNT_LO = 3'd0,
        CNT_HI = 3'd1,
        DATA   = 3'd2,
        CHK    = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t             state_r;
    logic [15:0]        count_r;
    logic [IDX_W-1:0]   idx_r;
    logic [1:0]         lane_r;
    logic [23:0]        word_r;
    logic [7:0]         chk_r;

    logic [15:0]        cnt_s;
    logic [IDX_W-1:0]   idx_inc_s;
    logic [31:0]        addr_s;

    // Header value as it stands on the high-byte strobe, next index and write address.
    always_comb begin
        cnt_s     = {iByte, count_r[7:0]};
        idx_inc_s = idx_r + IDX_W'(1);
        addr_s    = BASE_ADDR + (32'(idx_r) << 2'd2);
    end

    // Loader FSM with all outputs registered.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_r <= CNT_LO;
            count_r <= 16'd0;
            idx_r   <= '0;
            lane_r  <= 2'd0;
            word_r  <= 24'd0;
            chk_r   <= 8'd0;
            oWrEn   <= 1'b0;
            oWrAddr <= BASE_ADDR;
            oWrData <= 32'd0;
            oCpuRst <= 1'b1;
            oDone   <= 1'b0;
            oErr    <= 1'b0;
        end else begin
            oWrEn <= 1'b0;
            case (state_r)
                CNT_LO: begin
                    if (iByteValid) begin
                        count_r[7:0] <= iByte;
                        state_r      <= CNT_HI;
                    end
                end
                CNT_HI: begin
                    if (iByteValid) begin
                        count_r <= cnt_s;
                        idx_r   <= '0;
                        lane_r  <= 2'd0;
                        chk_r   <= 8'd0;
                        if ({1'b0, cnt_s} > DEPTH_W) begin
                            state_r <= ERR;
                            oErr    <= 1'b1;
                        end else if (cnt_s == 16'd0) begin
                            state_r <= CHK;
                        end else begin
                            state_r <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (iByteValid) begin
                        chk_r <= chk_r ^ iByte;
                        case (lane_r)
                            2'd0:    word_r[7:0]   <= iByte;
                            2'd1:    word_r[15:8]  <= iByte;
                            2'd2:    word_r[23:16] <= iByte;
                            default: begin
                                oWrData <= {iByte, word_r};
                                oWrAddr <= addr_s;
                                oWrEn   <= 1'b1;
                            end
                        endcase
                        lane_r <= lane_r + 2'd1;
                        if (lane_r == 2'd3) begin
                            idx_r <= idx_inc_s;
                            // Header was bounded by DEPTH, so the index cannot overflow here.
                            if (16'(idx_inc_s) == count_r) begin
                                state_r <= CHK;
                            end
                        end
                    end
                end
                CHK: begin
                    if (iByteValid) begin
                        if (iByte == chk_r) begin
                            state_r <= DONE;
                            oDone   <= 1'b1;
                            oCpuRst <= 1'b0;
                        end else begin
                            state_r <= ERR;
                            oErr    <= 1'b1;
                        end
                    end
                end
                DONE, ERR: begin
                    if (iStart) begin
                        state_r <= CNT_LO;
                        oDone   <= 1'b0;
                        oErr    <= 1'b0;
                        oCpuRst <= 1'b1;
                        idx_r   <= '0;
                        lane_r  <= 2'd0;
                        chk_r   <= 8'd0;
                    end
                end
                default: begin
                    state_r <= CNT_LO;
                    oErr    <= 1'b0;
                    oDone   <= 1'b0;
                    oCpuRst <= 1'b1;
                end
            endcase
        end
    end

endmodule
